// File: rtl/agc_envelope_monitor.sv
// rtl/agc_envelope_monitor.sv - peak envelope tracker (attack/hold/decay) with windowed peak, clip count and overload
module agc_envelope_monitor #(
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 16,
   parameter int DECAY_SHIFT = 4,
   parameter int WINDOW      = 256,
   parameter int CLIP_LEVEL  = 127,
   parameter int CLIP_ALARM  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_enable,
   input  logic signed [WIDTH-1:0] In1,
   output logic                    ce_out,
   output logic [WIDTH-1:0]        envelope,
   output logic [WIDTH-1:0]        peak_win,
   output logic [7:0]              clip_count,
   output logic                    win_valid,
   output logic                    overload
);

   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [WIDTH-1:0] MAG_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    CNT_LAST = CW'(WINDOW - 1);

   typedef enum logic [1:0] {S_ATTACK, S_HOLD, S_DECAY} state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_env, w_env_nx;
   logic [HW-1:0]    r_hold, w_hold_nx;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_run_max;
   logic [7:0]       r_run_clips;
   logic             r_ce_out;
   logic [WIDTH-1:0] r_peak_win;
   logic [7:0]       r_clip_count;
   logic             r_win_valid;
   logic             r_overload;

   logic [WIDTH-1:0] w_mag, w_step, w_dec, w_dec_env, w_max_now;
   logic             w_clip_now, w_last;
   logic [8:0]       w_clips_sum;
   logic [7:0]       w_clips_sat;

   // -128 has no positive counterpart, so it saturates to the largest magnitude
   always_comb begin
      w_mag = In1;
      if ($unsigned(In1) == MOST_NEG)
         w_mag = MAG_MAX;
      else if (In1[WIDTH-1])
         w_mag = -In1;
   end

   always_comb begin
      w_step = r_env >> DECAY_SHIFT;
      if (w_step == '0)
         w_step = WIDTH'(1);
      w_dec     = r_env - w_step;
      w_dec_env = (w_dec > w_mag) ? w_dec : w_mag;
   end

   always_comb begin
      w_state_nx = r_state;
      w_env_nx   = r_env;
      w_hold_nx  = r_hold;
      if (clk_enable) begin
         if (w_mag == '0 && r_env == '0) begin
            w_state_nx = S_DECAY;
         end else if (w_mag >= r_env) begin
            w_env_nx   = w_mag;
            w_hold_nx  = HW'(HOLD_CYCLES - 1);
            w_state_nx = S_ATTACK;
         end else if (r_state != S_DECAY) begin
            if (r_hold != '0) begin
               w_hold_nx  = r_hold - HW'(1);
               w_state_nx = S_HOLD;
            end else begin
               w_state_nx = S_DECAY;
            end
         end else begin
            w_env_nx = w_dec_env;
         end
      end
   end

   always_comb begin
      w_clip_now  = (w_mag >= WIDTH'(CLIP_LEVEL));
      w_clips_sum = {1'b0, r_run_clips} + 9'(w_clip_now);
      w_clips_sat = w_clips_sum[8] ? 8'hFF : w_clips_sum[7:0];
      w_max_now   = (w_mag > r_run_max) ? w_mag : r_run_max;
      w_last      = (r_cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_DECAY;
         r_env        <= '0;
         r_hold       <= '0;
         r_cnt        <= '0;
         r_run_max    <= '0;
         r_run_clips  <= '0;
         r_ce_out     <= 1'b0;
         r_peak_win   <= '0;
         r_clip_count <= '0;
         r_win_valid  <= 1'b0;
         r_overload   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_env       <= w_env_nx;
         r_hold      <= w_hold_nx;
         r_ce_out    <= clk_enable;
         r_win_valid <= 1'b0;
         if (clk_enable) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            // the closing sample belongs to the window it closes
            if (w_last) begin
               r_peak_win   <= w_max_now;
               r_clip_count <= w_clips_sat;
               r_overload   <= (w_clips_sat >= 8'(CLIP_ALARM));
               r_win_valid  <= 1'b1;
               r_run_max    <= '0;
               r_run_clips  <= '0;
            end else begin
               r_run_max    <= w_max_now;
               r_run_clips  <= w_clips_sat;
            end
         end
      end
   end

   assign ce_out     = r_ce_out;
   assign envelope   = r_env;
   assign peak_win   = r_peak_win;
   assign clip_count = r_clip_count;
   assign win_valid  = r_win_valid;
   assign overload   = r_overload;

endmodule

// File: doc/agc_envelope_monitor.md
# agc_envelope_monitor

Downstream monitor for the AGC output. It takes the AGC's signed 8-bit output samples and tracks a peak envelope with attack, hold and decay behaviour. Over fixed sample windows it reports the window peak and a clip count, and raises an overload flag. Its status outputs drive the bidirectional GPIO bank of the top-level wrapper, alongside the AGC.

## Interface
- WIDTH, 8: sample width; In1 is two's complement.
- HOLD_CYCLES, 16: enabled cycles the envelope is held after a new peak.
- DECAY_SHIFT, 4: decay step is env >> DECAY_SHIFT, minimum 1.
- WINDOW, 256: samples per measurement window; power of two.
- CLIP_LEVEL, 127: magnitude at or above which a sample counts as clipped.
- CLIP_ALARM, 4: clip count per window at or above which overload asserts.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_enable  in  1  sample strobe; when low, all state is frozen
- In1  in  WIDTH  AGC output sample, signed
- ce_out  out  1  clk_enable delayed one cycle, aligned with registered outputs
- envelope  out  WIDTH  current envelope, unsigned magnitude
- peak_win  out  WIDTH  maximum magnitude of the last completed window
- clip_count  out  8  clipped samples in the last completed window, saturating at 255
- win_valid  out  1  one-cycle pulse when peak_win and clip_count update
- overload  out  1  high when the latched clip_count ≥ CLIP_ALARM

## Operation
- Magnitude: mag = |In1|. The most negative input (-128) saturates to 127. mag is WIDTH bits, unsigned.
- Envelope FSM (states ATTACK, HOLD, DECAY). Evaluated only on cycles where clk_enable = 1.
  - Any state, mag ≥ env: env ← mag, hold ← HOLD_CYCLES−1, go to ATTACK.
  - ATTACK/HOLD, mag < env, hold > 0: hold ← hold−1, state HOLD.
  - ATTACK/HOLD, mag < env, hold = 0: go to DECAY.
  - DECAY, mag < env: step = max(env >> DECAY_SHIFT, 1); env ← max(env − step, mag). Never underflows.
  - env = 0 with mag = 0: stays in DECAY with env 0.
- Window logic:
  - The sample counter cnt runs 0..WINDOW−1 on enabled cycles and wraps.
  - run_max tracks the running maximum of mag.
  - run_clips counts samples with mag ≥ CLIP_LEVEL, saturating at 255.
  - On the enabled cycle where cnt = WINDOW−1:
    - peak_win ← max(run_max, mag).
    - clip_count ← sat255(run_clips + clipped_now).
    - win_valid pulses.
    - run_max and run_clips clear to 0.
    - cnt wraps to 0.
  - The current sample is included in the window it closes, not the next one.
- overload is registered. It updates together with clip_count and holds until the next window closes.
- clk_enable = 0:
  - No register changes, except that win_valid is forced to 0 and ce_out follows the delayed clk_enable.
- Reset (any cycle, including mid-window or mid-hold):
  - Every output goes to 0.
  - env = 0, hold = 0, state DECAY.
  - cnt, run_max and run_clips clear; the partial window is discarded.

## Timing
- One register stage. A sample presented on enabled edge n is reflected in envelope after edge n (visible in cycle n+1).
- win_valid, peak_win, clip_count and overload update on the same edge as the closing sample.
- ce_out is clk_enable delayed by exactly one clock.
- Reset takes priority over clk_enable.
- Throughput: one sample per enabled cycle, no stalls.
- The first window after reset closes on the WINDOW-th enabled sample.

## Test plan
- Reset, then In1 = 0x20 held with clk_enable = 1:
  - envelope = 32 from cycle 1 onward.
  - First win_valid after 256 samples, peak_win = 32, clip_count = 0, overload = 0.
- In1 = 100 for one sample, then 0:
  - envelope stays 100 for 16 enabled cycles.
  - Then decays 94, 89, 84, …; step is 1 once env < 16; reaches 0 with no underflow.
- In1 = 0x80 (−128): envelope = 127 and the sample counts as clipped.
- A 256-sample window with 5 samples of ±127 and all others |x| ≤ 50:
  - win_valid pulses once.
  - peak_win = 127, clip_count = 5, overload = 1.
  - Next clean window: clip_count = 0, overload = 0.
- clk_enable low for 10 cycles during HOLD:
  - envelope, hold and cnt are frozen; win_valid stays 0.
  - ce_out is low for 10 cycles, offset by one cycle.
  - Resuming continues the hold exactly where it stopped.
- Assert reset at sample 100 of a window:
  - All outputs 0 on the next cycle.
  - The following window closes 256 samples after reset release, with no residue from pre-reset samples.
